// File: rtl/ask_demod.sv
// rtl/ask_demod.sv - OOK/ASK demodulator: rectify, integrate-and-dump, adaptive threshold.
// Optional build macro ASK_DEMOD_DC_TRACK_EN replaces the fixed midscale offset with a tracked DC estimate.
module ask_demod #(
  parameter int DATA_W     = 12,
  parameter int SPS        = 1200,
  parameter int ACC_W      = 24,
  parameter int TRAIN_SYMS = 8,
  parameter int MIN_SPREAD = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sample_en,
  input  logic              resync,
  output logic [ACC_W-1:0]  energy,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              locked
);

  localparam int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int TCNT_W = $clog2(TRAIN_SYMS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SPS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TRAIN_SYMS - 1);
  localparam logic [ACC_W-1:0]  SPREAD_MIN = ACC_W'(MIN_SPREAD);
  localparam logic [DATA_W-1:0] R_MAX      = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {SETTLE, TRAIN, RUN} state_t;
  state_t state_q, state_d;

  logic [ACC_W-1:0]  acc_q, acc_d, energy_q, energy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ACC_W-1:0]  hi_q, hi_d, lo_q, lo_d, thr_q, thr_d;
  logic [ACC_W-1:0]  emax_q, emax_d, emin_q, emin_d;
  logic              bit_q, bit_d, valid_q, valid_d;

  logic signed [DATA_W-1:0] x;
  logic [DATA_W-1:0]        r;
  logic [ACC_W-1:0]         e_new, emax_n, emin_n, hi_n, lo_n;
  logic                     accept, dump, spread_ok, bit_n;
  logic signed [ACC_W:0]    d_hi, d_lo;

  assign accept = sample_en & ~resync;
  assign dump   = accept && (cnt_q == CNT_LAST);

`ifdef ASK_DEMOD_DC_TRACK_EN
  localparam logic signed [DATA_W+1:0] X_HI = (DATA_W+2)'(2**(DATA_W-1) - 1);
  localparam logic signed [DATA_W+1:0] X_LO = -(DATA_W+2)'(2**(DATA_W-1));
  logic [DATA_W+7:0]        dc_q, dc_d;
  logic signed [DATA_W+1:0] diff;

  always_comb begin
    diff = $signed({2'b00, adc_data}) - $signed({2'b00, dc_q[DATA_W+7:8]});
    if (diff > X_HI)      x = X_HI[DATA_W-1:0];
    else if (diff < X_LO) x = X_LO[DATA_W-1:0];
    else                  x = diff[DATA_W-1:0];
    dc_d = accept ? dc_q + {{6{diff[DATA_W+1]}}, diff} : dc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dc_q <= {1'b1, {(DATA_W+7){1'b0}}};
    else        dc_q <= dc_d;
  end
`else
  assign x = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`endif

  // The most negative code has no positive twin, so it clips to full scale.
  always_comb begin
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) r = R_MAX;
    else if (x[DATA_W-1])                r = -x;
    else                                 r = x;
  end

  assign e_new     = acc_q + {{(ACC_W-DATA_W){1'b0}}, r};
  assign emax_n    = (tcnt_q == '0 || e_new > emax_q) ? e_new : emax_q;
  assign emin_n    = (tcnt_q == '0 || e_new < emin_q) ? e_new : emin_q;
  assign spread_ok = (emax_n - emin_n) >= SPREAD_MIN;
  assign bit_n     = e_new > thr_q;
  assign d_hi      = ($signed({1'b0, e_new}) - $signed({1'b0, hi_q})) >>> 4;
  assign d_lo      = ($signed({1'b0, e_new}) - $signed({1'b0, lo_q})) >>> 4;
  assign hi_n      = bit_n ? ACC_W'($signed({1'b0, hi_q}) + d_hi) : hi_q;
  assign lo_n      = bit_n ? lo_q : ACC_W'($signed({1'b0, lo_q}) + d_lo);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SETTLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = SETTLE;
    end else if (dump) begin
      case (state_q)
        SETTLE:  state_d = TRAIN;
        TRAIN:   if (tcnt_q == TCNT_LAST && spread_ok) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == RUN);
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    energy_d = energy_q;
    tcnt_d   = tcnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    thr_d    = thr_q;
    emax_d   = emax_q;
    emin_d   = emin_q;
    bit_d    = bit_q;
    valid_d  = 1'b0;
    if (resync) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (dump) begin
      acc_d    = '0;
      cnt_d    = '0;
      energy_d = e_new;
      case (state_q)
        SETTLE: tcnt_d = '0;
        TRAIN: begin
          emax_d = emax_n;
          emin_d = emin_n;
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d = '0;
            if (spread_ok) begin
              hi_d  = emax_n;
              lo_d  = emin_n;
              thr_d = ACC_W'(({1'b0, emax_n} + {1'b0, emin_n}) >> 1);
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
          bit_d   = bit_n;
          valid_d = 1'b1;
          hi_d    = hi_n;
          lo_d    = lo_n;
          thr_d   = ACC_W'(({1'b0, hi_n} + {1'b0, lo_n}) >> 1);
        end
      endcase
    end else if (accept) begin
      acc_d = e_new;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      energy_q <= '0;
      tcnt_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      thr_q    <= '0;
      emax_q   <= '0;
      emin_q   <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      energy_q <= energy_d;
      tcnt_q   <= tcnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      thr_q    <= thr_d;
      emax_q   <= emax_d;
      emin_q   <= emin_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
    end
  end

  assign energy    = energy_q;
  assign bit_out   = bit_q;
  assign bit_valid = valid_q;

endmodule
